fetch_sequencer: RTL and testbench

- Controller for the instruction-fetch datapath: owns the PC, issues word reads to instruction memory and buffers the returned words in a small FIFO.
- Hands buffered words to decode over a valid/ready handshake.
- Handles control-flow redirects and end-of-program detection, replacing the free-running PC compare in the fetch stage.
- Sits between the PC/branch logic and decode.

---
 rtl/fetch_sequencer_if.sv | 20 ++
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction ROM read port plus the decode valid/ready handshake.
interface fetch_sequencer_if;
  logic        rom_rd;
  logic [31:0] rom_addr;
  logic [31:0] rom_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output rom_rd, rom_addr, instr_out, instr_pc, instr_valid,
    input  rom_rdata, instr_ready
  );

  modport slave (
    input  rom_rd, rom_addr, instr_out, instr_pc, instr_valid,
    output rom_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues ROM word reads, buffers words for decode (FETCH_PERF_EN adds perf counters).
// Latency: rom_rd in cycle N gives earliest instr_valid in cycle N+2; at most one read per cycle.
// Backpressure: reads stop while buffered plus in-flight words reach DEPTH; head holds while instr_ready=0.
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] rom_size,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fetch_complete,
  fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } entry_t;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   pending_pc;
  logic          in_flight;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [31:0]   limit;
  logic          flush;
  logic          nonempty;
  logic          has_room;
  logic          issue;
  logic          push;
  logic          pop;

  assign limit    = rom_size & ~32'h3;
  assign flush    = redirect && (state != S_IDLE);
  assign nonempty = (count != '0);
  // Credit check counts the word still in flight so a push can never overflow.
  assign has_room = (count + (AW+1)'(in_flight)) < (AW+1)'(DEPTH);
  assign issue    = (state == S_RUN) && (pc < limit) && has_room && !redirect;
  // Data of a read issued just before a redirect lands in the redirect cycle and is dropped.
  assign push     = in_flight && !flush;
  assign pop      = bus.instr_valid && bus.instr_ready;

  assign bus.rom_rd      = issue;
  assign bus.rom_addr    = issue ? pc : 32'h0;
  assign bus.instr_valid = nonempty && !redirect;
  assign bus.instr_out   = nonempty ? mem[rd_ptr].dat : 32'h0;
  assign bus.instr_pc    = nonempty ? mem[rd_ptr].pc  : 32'h0;

  assign busy           = (state == S_RUN) || (state == S_DRAIN);
  assign fetch_complete = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      pending_pc <= 32'h0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) pending_pc <= pc;
      if (flush) begin
        state <= S_RUN;
        pc    <= redirect_pc & ~32'h3;
      end else begin
        unique case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state <= S_RUN;
              pc    <= RESET_PC;
            end
          end
          S_RUN: begin
            if (pc >= limit) state <= S_DRAIN;
            else if (issue)  pc    <= pc + 32'd4;
          end
          S_DRAIN: begin
            if (!nonempty && !in_flight) state <= S_DONE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pending_pc, dat: bus.rom_rdata};
  end

`ifdef FETCH_PERF_EN
  logic accept_start;
  assign accept_start = start && !flush && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else if (accept_start) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (pop && (perf_fetched != 32'hFFFF_FFFF)) perf_fetched <= perf_fetched + 32'd1;
      if ((state == S_RUN) && !bus.instr_valid && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized runs checked against a stream-level model.
module tb_fetch_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rom_size = 32'h0;
  logic [31:0] redirect_pc = 32'h0;
  logic        busy;
  logic        fetch_complete;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_sequencer_if bus();

  fetch_sequencer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rom_size       (rom_size),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .fetch_complete (fetch_complete),
    .bus            (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stream model: next address expected on the ROM port and next PC expected at decode.
  logic [31:0] lim, base, exp_issue, exp_del;
  int          issued, delivered, gen;
  logic        hold_vld, want_first, last_rd;
  logic [31:0] hold_pc, hold_dat, first_pc, last_rd_addr;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]} + (32'(gen) << 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rom_rd"},      32'(bus.rom_rd), 32'h0);
    chk({tag, "_rom_addr"},    bus.rom_addr, 32'h0);
    chk({tag, "_instr_out"},   bus.instr_out, 32'h0);
    chk({tag, "_instr_pc"},    bus.instr_pc, 32'h0);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'h0);
    chk({tag, "_busy"},        32'(busy), 32'h0);
    chk({tag, "_complete"},    32'(fetch_complete), 32'h0);
  endtask

  task automatic observe();
    last_rd      = bus.rom_rd;
    last_rd_addr = bus.rom_addr;
    if (redirect && (busy || fetch_complete)) begin
      chk("redir_no_valid", 32'(bus.instr_valid), 32'h0);
      chk("redir_no_rd", 32'(bus.rom_rd), 32'h0);
      base       = redirect_pc & ~32'h3;
      exp_issue  = base;
      exp_del    = base;
      issued     = 0;
      delivered  = 0;
      hold_vld   = 1'b0;
      want_first = 1'b1;
      return;
    end
    if (hold_vld) begin
      chk("hold_valid", 32'(bus.instr_valid), 32'h1);
      chk("hold_pc", bus.instr_pc, hold_pc);
      chk("hold_dat", bus.instr_out, hold_dat);
    end
    if (bus.rom_rd) begin
      chk("rd_in_range", 32'(exp_issue < lim), 32'h1);
      chk("rd_credit", 32'((issued - delivered) < DEPTH), 32'h1);
      chk("rd_addr", bus.rom_addr, exp_issue);
      exp_issue += 32'd4;
      issued++;
    end
    if (bus.instr_valid && bus.instr_ready) begin
      if (want_first) begin
        first_pc   = bus.instr_pc;
        want_first = 1'b0;
      end
      chk("pop_pc", bus.instr_pc, exp_del);
      chk("pop_dat", bus.instr_out, rom_word(exp_del));
      exp_del += 32'd4;
      delivered++;
    end
    hold_vld = bus.instr_valid && !bus.instr_ready;
    hold_pc  = bus.instr_pc;
    hold_dat = bus.instr_out;
  endtask

  // Called just after a falling edge with this cycle's inputs already applied.
  task automatic cycle();
    #1;
    observe();
    @(posedge clk);
    #1;
    bus.rom_rdata = last_rd ? rom_word(last_rd_addr) : $urandom;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [31:0] size, input logic ready);
    rom_size        = size;
    lim             = size & ~32'h3;
    base            = 32'h0;
    exp_issue       = 32'h0;
    exp_del         = 32'h0;
    issued          = 0;
    delivered       = 0;
    hold_vld        = 1'b0;
    want_first      = 1'b1;
    bus.instr_ready = ready;
    start           = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd, input int nredir);
    int n = 0;
    int left = nredir;
    while (fetch_complete !== 1'b1 && n < budget) begin
      if (rnd) bus.instr_ready = ($urandom % 4) != 0;
      if (rnd && left > 0 && busy && ($urandom % 20) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom_range(0, int'(lim) + 3);
        left--;
      end
      cycle();
      redirect = 1'b0;
      n++;
    end
    chk("done", 32'(fetch_complete), 32'h1);
    chk("drained", 32'(issued - delivered), 32'h0);
    chk("end_pc", exp_del, (base > lim) ? base : lim);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    gen             = 0;
    bus.rom_rdata   = 32'h0;
    bus.instr_ready = 1'b0;
    lim             = 32'h0;
    hold_vld        = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Straight-line fetch: four consecutive reads, four in-order words.
    start_run(32'd16, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sl_rd_strobe", 32'(bus.rom_rd), 32'h1);
      cycle();
    end
    run_until_done(50, 1'b0, 0);
    chk("sl_rd_count", 32'(issued), 32'd4);
    chk("sl_pops", 32'(delivered), 32'd4);

    // Backpressure: credit limits reads to DEPTH while decode stalls.
    start_run(32'd64, 1'b0);
    repeat (10) cycle();
    chk("bp_rd_count", 32'(issued), 32'(DEPTH));
    #1;
    chk("bp_rd_idle", 32'(bus.rom_rd), 32'h0);
    chk("bp_head_valid", 32'(bus.instr_valid), 32'h1);
    chk("bp_head_pc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1;
    run_until_done(200, 1'b0, 0);
    chk("bp_pops", 32'(delivered), 32'd16);

    // Redirect while the read of address 8 is in flight.
    start_run(32'd64, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_rd && last_rd_addr == 32'h8) break;
    end
    chk("ri_saw_rd8", last_rd_addr, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h23;
    cycle();
    redirect = 1'b0;
    run_until_done(200, 1'b0, 0);
    chk("ri_first_pc", first_pc, 32'h20);
    chk("ri_pops", 32'(delivered), 32'd8);

    // Redirect from DONE refetches the program.
    start_run(32'd8, 1'b1);
    run_until_done(50, 1'b0, 0);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    cycle();
    redirect = 1'b0;
    #1;
    chk("rd_complete_drop", 32'(fetch_complete), 32'h0);
    run_until_done(50, 1'b0, 0);
    chk("rd_pops", 32'(delivered), 32'd2);

    // Program smaller than a word fetches nothing.
    begin
      int n = 0;
      start_run(32'd2, 1'b1);
      while (fetch_complete !== 1'b1 && n < 10) begin
        cycle();
        n++;
      end
      chk("empty_done", 32'(fetch_complete), 32'h1);
      chk("empty_fast", 32'(n <= 2), 32'h1);
      chk("empty_no_rd", 32'(issued), 32'h0);
    end

    // Asynchronous reset with three words buffered and one in flight.
    start_run(32'd64, 1'b0);
    repeat (4) cycle();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    gen++;
    start_run(32'd8, 1'b1);
    run_until_done(50, 1'b0, 0);
    chk("mr_pops", 32'(delivered), 32'd2);

    // Randomized programs, decode stalls and redirects.
    for (int r = 0; r < 12; r++) begin
      gen++;
      start_run($urandom_range(0, 96), 1'b1);
      run_until_done(3000, 1'b1, 3);
    end

`ifdef FETCH_PERF_EN
    gen++;
    start_run(32'd16, 1'b0);
    repeat (5) cycle();
    bus.instr_ready = 1'b1;
    run_until_done(50, 1'b0, 0);
    chk("perf_fetched", perf_fetched, 32'd4);
    chk("perf_stall", perf_stall, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
